// File: rtl/eq_result_tracker.sv
// rtl/eq_result_tracker.sv - tagged result tracker and match statistics for a pipelined equality comparator
//
// Purpose:
//   Carries a valid bit and a tag next to every operand pair issued to the
//   comparator. These are delayed so that they line up with the comparator's
//   eq output. Each issued compare produces one registered, tagged match or
//   mismatch event. The block also keeps saturating match and mismatch
//   counts, the current and longest consecutive-match run, and a one-shot
//   pulse when the run reaches RUN_THRESH.
//
// Ports:
//   clk            in   rising-edge system clock
//   rst            in   asynchronous active-high reset
//   in_valid       in   compare issued (sampled on the same edge as the comparator operands)
//   in_tag         in   tag of the issued compare
//   eq             in   comparator result, valid LATENCY-1 edges after issue
//   clear          in   synchronous clear of all statistics
//   out_valid      out  one-cycle strobe per resolved compare
//   out_tag        out  tag of the resolved compare (held when out_valid=0)
//   out_match      out  eq of the resolved compare (held when out_valid=0)
//   match_count    out  saturating count of matches
//   mismatch_count out  saturating count of mismatches
//   run_len        out  current consecutive-match run, saturating
//   max_run        out  longest run since reset/clear
//   run_hit        out  pulse when run_len moves to RUN_THRESH

module eq_result_tracker #(
    parameter int TAG_W      = 8,
    parameter int LATENCY    = 3,
    parameter int CNT_W      = 16,
    parameter int RUN_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             eq,
    input  logic             clear,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_match,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] max_run,
    output logic             run_hit
);

    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(RUN_THRESH - 1);

    // Stage 0 is the capture of in_valid/in_tag on the issue edge. It is
    // followed by LATENCY-1 delay stages. The last stage is therefore
    // populated after issue edge + LATENCY-1, which is the point where eq for
    // the same compare becomes stable. Both are then combined on the next
    // edge into the output registers.
    logic [LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];

    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    logic             out_match_q, out_match_d;
    logic [CNT_W-1:0] match_q,     match_d;
    logic [CNT_W-1:0] mismatch_q,  mismatch_d;
    logic [CNT_W-1:0] run_q,       run_d;
    logic [CNT_W-1:0] max_q,       max_d;
    logic             hit_q,       hit_d;

    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [CNT_W-1:0] run_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign res_valid = vld_q[LATENCY-1];
    assign res_tag   = tag_q[LATENCY-1];
    assign run_inc   = sat_inc(run_q);

    always_comb begin
        out_valid_d = res_valid;
        out_tag_d   = out_tag_q;
        out_match_d = out_match_q;
        match_d     = match_q;
        mismatch_d  = mismatch_q;
        run_d       = run_q;
        max_d       = max_q;
        hit_d       = 1'b0;

        if (res_valid) begin
            out_tag_d   = res_tag;
            out_match_d = eq;
            if (eq) begin
                match_d = sat_inc(match_q);
                run_d   = run_inc;
                max_d   = (run_inc > max_q) ? run_inc : max_q;
                // THRESH_M1 is below all-ones, so this increment is never saturated.
                // The pulse therefore fires exactly once per run.
                hit_d   = (run_q == THRESH_M1);
            end else begin
                mismatch_d = sat_inc(mismatch_q);
                run_d      = '0;
            end
        end

        // Clear takes priority over a result resolving on the same edge, but
        // only for the statistics; the event outputs above still go out.
        if (clear) begin
            match_d    = '0;
            mismatch_d = '0;
            run_d      = '0;
            max_d      = '0;
            hit_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_match_q <= 1'b0;
            match_q     <= '0;
            mismatch_q  <= '0;
            run_q       <= '0;
            max_q       <= '0;
            hit_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_match_q <= out_match_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            run_q       <= run_d;
            max_q       <= max_d;
            hit_q       <= hit_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_tag        = out_tag_q;
    assign out_match      = out_match_q;
    assign match_count    = match_q;
    assign mismatch_count = mismatch_q;
    assign run_len        = run_q;
    assign max_run        = max_q;
    assign run_hit        = hit_q;

endmodule

// File: doc/eq_result_tracker.md
Name: eq_result_tracker

Overview:
Downstream consumer of the pipelined wide equality comparator. It carries a valid bit and a tag alongside each operand pair issued to the comparator, delayed to match the comparator latency, and pairs them with the comparator's eq output. It produces one tagged match/mismatch event per issued compare. It also keeps saturating match/mismatch statistics, the current and longest consecutive-match run, and a one-shot run-threshold alarm.

Parameters:
TAG_W, 8, width of the tag carried with each compare
LATENCY, 3, comparator latency in clocks; legal range 1..16
CNT_W, 16, width of the statistics counters and run counters
RUN_THRESH, 4, consecutive-match count that fires run_hit; legal range 1..2^CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  a compare is issued this cycle (same edge the comparator samples a/b)
in_tag  in  TAG_W  tag of the issued compare
eq  in  1  comparator result, aligned per the Behaviour section
clear  in  1  synchronous clear of statistics
out_valid  out  1  result event strobe, one cycle per issued compare
out_tag  out  TAG_W  tag of the resolved compare
out_match  out  1  eq value for the resolved compare
match_count  out  CNT_W  saturating count of matched results
mismatch_count  out  CNT_W  saturating count of mismatched results
run_len  out  CNT_W  current consecutive-match run, saturating
max_run  out  CNT_W  longest run_len since reset/clear
run_hit  out  1  one-cycle pulse when run_len becomes RUN_THRESH

Behaviour:
- Reset (rst=1, asynchronous): all outputs are 0, and all delay-line valid and tag stages are 0. Reset asserted mid-stream discards all in-flight compares; no out_valid appears for them after release.
- Alignment: operands and in_valid/in_tag are sampled at edge N. eq for that pair is stable after edge N+LATENCY-1.
- A delay line of LATENCY-1 register stages carries valid and tag. With LATENCY=1 there are no stages; in_valid and in_tag are combined with eq at the next edge.
- Resolution: at edge N+LATENCY, if the delayed valid is 1, the block registers the following:
  - out_valid=1
  - out_tag=delayed tag
  - out_match=eq
- Latency: out_valid is high in the cycle after edge N+LATENCY, i.e. LATENCY clocks after in_valid.
- eq is ignored whenever the delayed valid is 0. In that case out_valid=0, and out_tag and out_match hold their previous values.
- Back-to-back: in_valid may be high every cycle. There is no backpressure and no stall; every issued compare yields exactly one out_valid, in issue order.
- On each resolved match:
  - match_count +1, saturating at all-ones
  - run_len +1, saturating
  - max_run <= max(max_run, new run_len)
- On each resolved mismatch: mismatch_count +1, saturating; run_len <= 0; max_run unchanged.
- Non-valid cycles leave all statistics unchanged.
- run_hit pulses for exactly one cycle, registered together with out_valid, when a match moves run_len from RUN_THRESH-1 to RUN_THRESH. It does not re-fire until a mismatch or clear resets the run.
- clear (sync, sampled on rising edge):
  - Zeroes match_count, mismatch_count, run_len and max_run; run_hit=0 that cycle.
  - Does not flush the delay line and does not suppress out_valid/out_tag/out_match.
  - If a result resolves on the same edge, clear wins for all statistics and run_hit, and the event outputs are still emitted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Single issue, LATENCY=3: in_valid=1, in_tag=0x5A at edge 10, eq=1 → out_valid high only in the cycle after edge 13; out_tag=0x5A, out_match=1, match_count=1, run_len=1.
- Streaming: 6 consecutive issues with tags 0..5, eq=1,1,1,1,0,1 →
  - six contiguous out_valid pulses, tags in order
  - run_hit only on tag 3
  - run_len ends at 1, max_run=4
  - match_count=5, mismatch_count=1
- Saturation with CNT_W=4: 20 consecutive matches → match_count, run_len and max_run stick at 15; no wrap to 0; run_hit fires once.
- Clear collision: clear=1 on the same edge a match resolves with tag 0x22 → out_valid=1, out_tag=0x22, out_match=1; all counters read 0 the next cycle; run_hit=0.
- Reset mid-flight: issue 3 compares, assert rst for 1 cycle before any resolves → no out_valid for 10 cycles after release; all outputs 0.
- LATENCY=1 build: in_valid at edge N with eq=0 → out_valid in the cycle after edge N+1, out_match=0, mismatch_count=1.
